// File: rtl/morse_keyer_if.sv
// Pattern handshake between the scancode-to-Morse encoder (master) and the keyer (slave).
interface morse_keyer_if;
  logic       sym_valid;
  logic [2:0] sym_len;
  logic [3:0] sym_bits;
  logic       sym_ready;

  modport master (output sym_valid, output sym_len, output sym_bits, input sym_ready);
  modport slave  (input sym_valid, input sym_len, input sym_bits, output sym_ready);
endinterface

// File: rtl/morse_keyer.sv
// Plays one letter's Morse pattern (1-4 elements) as a timed key signal with busy/done status.
// Optional buzzer square wave on tone_out when MORSE_KEYER_TONE_EN is defined.
module morse_keyer #(
`ifdef MORSE_KEYER_TONE_EN
  parameter int unsigned TONE_HALF   = 50_000,
`endif
  parameter int unsigned UNIT_CYCLES = 12_500_000
) (
  input  logic          clk,
  input  logic          rst_n,
  morse_keyer_if.slave  sym,
  output logic          key_out,
`ifdef MORSE_KEYER_TONE_EN
  output logic          tone_out,
`endif
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_GAP} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [1:0]     unit_q, unit_d;
  logic [3:0]     bits_q, bits_d;
  logic [1:0]     elem_q, elem_d;
  logic           key_q, busy_q, done_q, ready_q;
  logic           key_d, busy_d, done_d, ready_d;
  logic           unit_end, take, legal;
  logic [1:0]     mark_last_unit;

  // Next-state, counter and output computation
  always_comb begin
    unit_end       = (cyc_q == CW'(UNIT_CYCLES - 1));
    mark_last_unit = bits_q[3] ? 2'd2 : 2'd0;
    take           = sym.sym_valid && ready_q;
    legal          = (sym.sym_len != 3'd0) && (sym.sym_len <= 3'd4);

    state_d = state_q;
    cyc_d   = unit_end ? '0 : cyc_q + CW'(1);
    unit_d  = unit_end ? unit_q + 2'd1 : unit_q;
    bits_d  = bits_q;
    elem_d  = elem_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cyc_d  = '0;
        unit_d = '0;
      end
      S_MARK: begin
        if (unit_end && (unit_q == mark_last_unit)) begin
          state_d = (elem_q != 2'd0) ? S_SPACE : S_GAP;
          cyc_d   = '0;
          unit_d  = '0;
        end
      end
      S_SPACE: begin
        if (unit_end) begin
          state_d = S_MARK;
          bits_d  = {bits_q[2:0], 1'b0};
          elem_d  = elem_q - 2'd1;
          cyc_d   = '0;
          unit_d  = '0;
        end
      end
      S_GAP: begin
        if (unit_end && (unit_q == 2'd2)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          bits_d  = '0;
          elem_d  = '0;
          cyc_d   = '0;
          unit_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        unit_d  = '0;
      end
    endcase

    // ready_q is only high in IDLE or the final gap cycle, so a take always starts from a clean slot
    if (take) begin
      cyc_d  = '0;
      unit_d = '0;
      if (legal) begin
        state_d = S_MARK;
        bits_d  = sym.sym_bits;
        elem_d  = 2'(sym.sym_len - 3'd1);
      end
    end

    key_d   = (state_d == S_MARK);
    busy_d  = (state_d != S_IDLE);
    // Pre-assert ready in the last gap cycle so a waiting letter starts right at the done edge
    ready_d = (state_d == S_IDLE) ||
              ((state_d == S_GAP) && (unit_d == 2'd2) && (cyc_d == CW'(UNIT_CYCLES - 1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      bits_q  <= '0;
      elem_q  <= '0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      bits_q  <= bits_d;
      elem_q  <= elem_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign key_out       = key_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sym.sym_ready = ready_q;

`ifdef MORSE_KEYER_TONE_EN
  localparam int unsigned TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  logic [TW-1:0] tone_cnt_q;
  logic          tone_q;

  // Square wave runs only while the key stays on; each mark restarts it low
  always_ff @(posedge clk) begin
    if (!rst_n || !key_d || !key_q) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (tone_cnt_q == TW'(TONE_HALF - 1)) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + TW'(1);
    end
  end

  assign tone_out = tone_q;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Directed plus randomized check of morse_keyer against a waveform model built from Morse timing rules.
module tb_morse_keyer;
  localparam int U  = 4;
  localparam int TH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_out, busy, done;
`ifdef MORSE_KEYER_TONE_EN
  logic tone_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  morse_keyer_if sif ();

  morse_keyer #(
`ifdef MORSE_KEYER_TONE_EN
    .TONE_HALF(TH),
`endif
    .UNIT_CYCLES(U)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sym     (sif),
    .key_out (key_out),
`ifdef MORSE_KEYER_TONE_EN
    .tone_out(tone_out),
`endif
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for ready, then present one pattern for exactly one edge
  task automatic send(input logic [2:0] len, input logic [3:0] bits);
    int w = 0;
    while (sif.sym_ready !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    chk("send_ready", sif.sym_ready, 1'b1);
    sif.sym_valid = 1'b1;
    sif.sym_len   = len;
    sif.sym_bits  = bits;
    tick();
    sif.sym_valid = 1'b0;
  endtask

  // Entered in the cycle after the acceptance edge; leaves in the done cycle
  task automatic run_letter(input logic [2:0] len, input logic [3:0] bits,
                            input bit chained, input string nm);
    bit wk[$];
    bit wt[$];
    for (int e = 0; e < int'(len); e++) begin
      int mu = bits[3 - e] ? 3 * U : U;
      int gu = (e == int'(len) - 1) ? 3 * U : U;
      for (int p = 0; p < mu; p++) begin
        wk.push_back(1'b1);
        wt.push_back(((p / TH) % 2) == 1);
      end
      for (int p = 0; p < gu; p++) begin
        wk.push_back(1'b0);
        wt.push_back(1'b0);
      end
    end
    for (int i = 0; i < wk.size(); i++) begin
      chk({nm, "_key"}, key_out, wk[i]);
      chk({nm, "_busy"}, busy, 1'b1);
      if (i > 0) chk({nm, "_done_early"}, done, 1'b0);
      if (i < wk.size() - 1) chk({nm, "_ready_busy"}, sif.sym_ready, 1'b0);
`ifdef MORSE_KEYER_TONE_EN
      chk({nm, "_tone"}, tone_out, wt[i]);
`endif
      tick();
    end
    chk({nm, "_done"}, done, 1'b1);
    if (!chained) begin
      chk({nm, "_done_busy"}, busy, 1'b0);
      chk({nm, "_done_ready"}, sif.sym_ready, 1'b1);
      chk({nm, "_done_key"}, key_out, 1'b0);
    end else begin
      chk({nm, "_next_key"}, key_out, 1'b1);
      chk({nm, "_next_busy"}, busy, 1'b1);
      chk({nm, "_next_ready"}, sif.sym_ready, 1'b0);
    end
  endtask

  initial begin
    logic [2:0] cur_len, nxt_len, bad_len;
    logic [3:0] cur_bits, nxt_bits;
    bit chain;

    sif.sym_valid = 1'b0;
    sif.sym_len   = '0;
    sif.sym_bits  = '0;

    // Reset held for 5 cycles
    repeat (5) begin
      tick();
      chk("rst_key", key_out, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ready", sif.sym_ready, 1'b0);
`ifdef MORSE_KEYER_TONE_EN
      chk("rst_tone", tone_out, 1'b0);
`endif
    end
    rst_n = 1'b1;
    tick();
    chk("release_ready", sif.sym_ready, 1'b1);
    chk("release_busy", busy, 1'b0);

    // Letter E
    send(3'd1, 4'b0000);
    run_letter(3'd1, 4'b0000, 1'b0, "E");
    tick();
    chk("E_done_single", done, 1'b0);
    chk("E_idle_ready", sif.sym_ready, 1'b1);

    // Letter Q with A waiting back-to-back
    send(3'd4, 4'b1101);
    sif.sym_valid = 1'b1;
    sif.sym_len   = 3'd2;
    sif.sym_bits  = 4'b0100;
    run_letter(3'd4, 4'b1101, 1'b1, "Q");
    sif.sym_valid = 1'b0;
    run_letter(3'd2, 4'b0100, 1'b0, "A");
    tick();

    // Illegal lengths are swallowed
    for (int k = 0; k < 2; k++) begin
      bad_len = (k == 0) ? 3'd0 : 3'($urandom_range(5, 7));
      send(bad_len, 4'($urandom));
      for (int c = 0; c < 6; c++) begin
        chk("bad_ready", sif.sym_ready, 1'b1);
        chk("bad_key", key_out, 1'b0);
        chk("bad_busy", busy, 1'b0);
        chk("bad_done", done, 1'b0);
        tick();
      end
    end

    // Reset mid-dash of T
    send(3'd1, 4'b1000);
    repeat (6) tick();
    chk("T_mid_key", key_out, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("abort_key", key_out, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_ready", sif.sym_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_release_ready", sif.sym_ready, 1'b1);
    for (int c = 0; c < 12; c++) begin
      chk("abort_no_done", done, 1'b0);
      chk("abort_quiet_key", key_out, 1'b0);
      tick();
    end

    // Random letters, some chained back-to-back
    cur_len  = 3'($urandom_range(1, 4));
    cur_bits = 4'($urandom);
    send(cur_len, cur_bits);
    for (int k = 0; k < 8; k++) begin
      chain = (k < 7) && ($urandom_range(0, 1) == 1);
      if (chain) begin
        nxt_len  = 3'($urandom_range(1, 4));
        nxt_bits = 4'($urandom);
        sif.sym_valid = 1'b1;
        sif.sym_len   = nxt_len;
        sif.sym_bits  = nxt_bits;
        run_letter(cur_len, cur_bits, 1'b1, "rand_chain");
        sif.sym_valid = 1'b0;
        cur_len  = nxt_len;
        cur_bits = nxt_bits;
      end else begin
        run_letter(cur_len, cur_bits, 1'b0, "rand");
        if (k < 7) begin
          if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) tick();
          cur_len  = 3'($urandom_range(1, 4));
          cur_bits = 4'($urandom);
          send(cur_len, cur_bits);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Downstream stage of the scancode-to-Morse encoder: accepts one letter's Morse pattern (up to four dot/dash elements) per valid/ready handshake and plays it out as a timed on/off key signal for the board LED/buzzer. Timing follows standard Morse ratios in units of `UNIT_CYCLES` clocks. It also provides a letter-complete pulse and a busy flag to the game/mode controller.

## Interface
- `UNIT_CYCLES`, default 12_500_000: clocks per Morse unit (0.125 s at 100 MHz); legal range ≥1.
- `TONE_HALF`, default 50_000: half-period in clocks of the buzzer square wave (1 kHz at 100 MHz). Used only with `MORSE_KEYER_TONE_EN`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `sym_valid`  in  1  the upstream pattern is valid.
- `sym_len`  in  3  element count; legal values are 1–4.
- `sym_bits`  in  4  elements; bit 3 is played first; 1 = dash, 0 = dot; unused low bits are ignored.
- `sym_ready`  out  1  the block can accept a pattern.
- `key_out`  out  1  Morse key (high = mark).
- `tone_out`  out  1  gated square wave. Present only with `MORSE_KEYER_TONE_EN`.
- `busy`  out  1  a letter is in progress.
- `done`  out  1  one-cycle pulse when the letter and its trailing gap are complete.

## Operation
- FSM states:
  - IDLE: `sym_ready`=1.
  - MARK: `key_out`=1.
  - SPACE: intra-letter gap.
  - GAP: inter-letter gap.
- Durations: dot mark 1 unit; dash mark 3 units; SPACE 1 unit; GAP 3 units.
- A transfer occurs on a rising edge with `sym_valid`=1, `sym_ready`=1 and `rst_n`=1.
  - `sym_len`/`sym_bits` are latched into a shift register and an element counter.
  - The FSM then goes to MARK.
- Illegal length (`sym_len` = 0 or >4): the handshake completes, the pattern is discarded, and the FSM stays in IDLE. No `key_out` activity and no `done`.
- Counters:
  - The cycle counter counts 0..UNIT_CYCLES−1.
  - The unit counter counts units within the current state.
  - Both clear on every state change.
- Transitions:
  - MARK end: go to SPACE if elements remain, else go to GAP.
  - SPACE end: shift to the next element and go to MARK.
  - GAP end: go to IDLE and pulse `done`.
- `busy` = (state != IDLE).
- Inputs are ignored outside IDLE; upstream must hold `sym_valid` until `sym_ready`.
- Reset mid-letter aborts immediately:
  - The FSM returns to IDLE and the shift register and counters clear.
  - No `done` is produced for the aborted letter.

## Timing
- All outputs are registered.
- Reset values: `key_out`=0, `tone_out`=0, `busy`=0, `done`=0, `sym_ready`=0.
- `sym_ready` rises in the first cycle after `rst_n` goes high.
- Acceptance edge E0:
  - `key_out`=1 and `busy`=1 from E0; `sym_ready`=0 from E0.
- Total units T = Σ(marks) + (len−1) + 3.
  - `done`=1 for exactly one cycle, starting at edge E0 + T·UNIT_CYCLES.
  - In that same cycle `busy`=0 and `sym_ready`=1.
- Back-to-back: if `sym_valid` is high in the `done` cycle, it is accepted at that edge. The next mark starts with no extra idle cycle, so the 3-unit gap is preserved exactly.
- Each mark is exactly 1×/3× UNIT_CYCLES cycles of `key_out`=1; each gap is exact. There is no glitch between consecutive units.
- `UNIT_CYCLES`=1 must work: a dot is a single-cycle mark.

## Configuration
- `MORSE_KEYER_TONE_EN` defined:
  - Adds the `tone_out` port and a half-period counter (0..TONE_HALF−1).
  - `tone_out` toggles each time the counter wraps while `key_out`=1.
  - `tone_out` is forced to 0, with the counter cleared, whenever `key_out`=0 or in reset.
  - Each mark therefore starts with `tone_out`=0.
- Undefined: no `tone_out` port and no tone counter. `key_out` drives the buzzer directly; all other behaviour is identical.

## Test plan
All scenarios use UNIT_CYCLES=4 and TONE_HALF=2.
- Reset: hold `rst_n`=0 for 5 cycles → all outputs 0; `sym_ready`=1 in the first cycle after release.
- Letter E (len=1, bits=0000) accepted at E0 → `key_out` high for cycles E0..E0+3, low for 12 cycles; `done` pulses at E0+16; `busy` high for exactly 16 cycles.
- Letter Q (len=4, bits=1101), sent back-to-back with A (len=2, bits=0100) held valid:
  - Q key_out pattern: 12 high, 4 low, 12 high, 4 low, 4 high, 4 low, 12 high, then 12 low.
  - Q `done` at E0+64.
  - A is accepted on the same edge; A's first mark starts at E0+64.
- Illegal len=0 with `sym_valid` for 1 cycle → `sym_ready` stays 1, `key_out`/`busy`/`done` stay 0.
- Reset asserted mid-dash of T (len=1, bits=1000) at E0+6 → at the next edge `key_out`=0 and `busy`=0; no `done`; `sym_ready`=1 after release.
- With `MORSE_KEYER_TONE_EN`, letter E → `tone_out` is 0,0,1,1 across the 4 mark cycles and 0 throughout the gap.
